// File: rtl/l1_ptr_ctrl.sv
// Purpose : per-stream L1 read/write pointer and occupancy controller; grants port reads in port-priority order.
// Latency : readies and o_wr_ptr are combinational; o_ptrs/o_cnt/o_act update one cycle after a handshake.
// Backpr. : read ready only for ACTIVE streams with enough entries; write ready only while the stream is not full.
//
// Ports:
//   clk, reset                    clock, async active-low reset
//   i_req_v / i_req_r             read request/ready, bit [p*nstrms+s] = port p, stream s
//   i_wr_v / i_wr_r / i_wr_sid    refill write handshake and its stream
//   o_wr_ptr                      write pointer of i_wr_sid (BRAM write address low bits)
//   i_srst_v / i_srst_r / i_srst_sid  stream restart (flush) handshake
//   o_ptrs / o_cnt / o_act        registered per-stream read pointer, occupancy, active flag
module l1_ptr_ctrl #(
   parameter int nstrms    = 64,
   parameter int sid_width = $clog2(nstrms),
   parameter int nports    = 8,
   parameter int ptr_width = 4,
   parameter int cnt_width = ptr_width + 1,
   parameter int gnt_width = $clog2(nports + 1)
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic [nports*nstrms-1:0]      i_req_v,
   output logic [nports*nstrms-1:0]      i_req_r,
   input  logic                          i_wr_v,
   output logic                          i_wr_r,
   input  logic [sid_width-1:0]          i_wr_sid,
   output logic [ptr_width-1:0]          o_wr_ptr,
   input  logic                          i_srst_v,
   output logic                          i_srst_r,
   input  logic [sid_width-1:0]          i_srst_sid,
   output logic [nstrms*ptr_width-1:0]   o_ptrs,
   output logic [nstrms*cnt_width-1:0]   o_cnt,
   output logic [nstrms-1:0]             o_act
);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_FLUSH  = 2'd1,
      ST_ACTIVE = 2'd2
   } state_t;

   localparam logic [cnt_width-1:0] DEPTH_C = cnt_width'(2**ptr_width);

   state_t               r_state   [nstrms];
   state_t               w_state_nx[nstrms];
   logic [ptr_width-1:0] r_rd_ptr  [nstrms];
   logic [ptr_width-1:0] r_wr_ptr  [nstrms];
   logic [cnt_width-1:0] r_cnt     [nstrms];
   logic [gnt_width-1:0] w_gnt     [nstrms];
   logic [nstrms-1:0]    w_srst_hit;
   logic [nstrms-1:0]    w_wr_inc;
   logic                 w_wr_acc;

   // Restart is accepted whenever the block is out of reset.
   assign i_srst_r = reset;

   always_comb begin
      w_srst_hit = '0;
      for (int s = 0; s < nstrms; s++) begin
         w_srst_hit[s] = i_srst_v & i_srst_r & (i_srst_sid == sid_width'(s));
      end
   end

   // Read grant: a request is served if fewer lower-index ports ask for the
   // same stream than there are entries, so grants form a contiguous prefix
   // matching the read ports' ptr+rank addressing.
   always_comb begin
      logic [cnt_width-1:0] v_rank;
      v_rank  = '0;
      i_req_r = '0;
      for (int s = 0; s < nstrms; s++) begin
         w_gnt[s] = '0;
         v_rank   = '0;
         for (int p = 0; p < nports; p++) begin
            if (i_req_v[p*nstrms + s]) begin
               if ((r_state[s] == ST_ACTIVE) && !w_srst_hit[s] && (v_rank < r_cnt[s])) begin
                  i_req_r[p*nstrms + s] = 1'b1;
                  w_gnt[s]              = w_gnt[s] + gnt_width'(1);
               end
               v_rank = v_rank + cnt_width'(1);
            end
         end
      end
   end

   // Write side: cnt is the registered value, so an entry written this
   // cycle cannot be granted to a reader in the same cycle.
   assign i_wr_r   = (r_state[i_wr_sid] == ST_ACTIVE) &&
                     (r_cnt[i_wr_sid] < DEPTH_C) &&
                     !w_srst_hit[i_wr_sid];
   assign w_wr_acc = i_wr_v & i_wr_r;
   assign o_wr_ptr = r_wr_ptr[i_wr_sid];

   always_comb begin
      w_wr_inc = '0;
      for (int s = 0; s < nstrms; s++) begin
         w_wr_inc[s] = w_wr_acc & (i_wr_sid == sid_width'(s));
      end
   end

   // Per-stream FSM next state; a restart while flushing extends the flush.
   always_comb begin
      for (int s = 0; s < nstrms; s++) begin
         w_state_nx[s] = r_state[s];
         case (r_state[s])
            ST_IDLE:   if (w_srst_hit[s]) w_state_nx[s] = ST_FLUSH;
            ST_FLUSH:  w_state_nx[s] = w_srst_hit[s] ? ST_FLUSH : ST_ACTIVE;
            ST_ACTIVE: if (w_srst_hit[s]) w_state_nx[s] = ST_FLUSH;
            default:   w_state_nx[s] = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int s = 0; s < nstrms; s++) begin
            r_state[s]  <= ST_IDLE;
            r_rd_ptr[s] <= '0;
            r_wr_ptr[s] <= '0;
            r_cnt[s]    <= '0;
         end
      end else begin
         for (int s = 0; s < nstrms; s++) begin
            r_state[s] <= w_state_nx[s];
            if (r_state[s] == ST_FLUSH) begin
               r_rd_ptr[s] <= '0;
               r_wr_ptr[s] <= '0;
               r_cnt[s]    <= '0;
            end else if (r_state[s] == ST_ACTIVE) begin
               // Pointers wrap naturally at D; grant count never exceeds cnt.
               r_rd_ptr[s] <= r_rd_ptr[s] + ptr_width'(w_gnt[s]);
               r_wr_ptr[s] <= r_wr_ptr[s] + ptr_width'(w_wr_inc[s]);
               r_cnt[s]    <= r_cnt[s] - cnt_width'(w_gnt[s]) + cnt_width'(w_wr_inc[s]);
            end
         end
      end
   end

   always_comb begin
      o_ptrs = '0;
      o_cnt  = '0;
      o_act  = '0;
      for (int s = 0; s < nstrms; s++) begin
         o_ptrs[s*ptr_width +: ptr_width] = r_rd_ptr[s];
         o_cnt[s*cnt_width +: cnt_width]  = r_cnt[s];
         o_act[s]                         = (r_state[s] == ST_ACTIVE);
      end
   end

endmodule

// File: tb/tb_l1_ptr_ctrl.sv
// Purpose : self-checking bench for l1_ptr_ctrl, stream 3 traffic with scoreboarded pointer/occupancy.
// Latency : expectations are queued with each driven cycle and popped one cycle later.
// Backpr. : readies are checked combinationally before each clock edge.
module tb_l1_ptr_ctrl;
   localparam int NS = 64;
   localparam int NP = 8;
   localparam int PW = 4;
   localparam int CW = 5;
   localparam int SW = 6;
   localparam int D  = 16;

   logic               clk = 1'b0;
   logic               reset;
   logic [NP*NS-1:0]   i_req_v;
   logic [NP*NS-1:0]   i_req_r;
   logic               i_wr_v;
   logic               i_wr_r;
   logic [SW-1:0]      i_wr_sid;
   logic [PW-1:0]      o_wr_ptr;
   logic               i_srst_v;
   logic               i_srst_r;
   logic [SW-1:0]      i_srst_sid;
   logic [NS*PW-1:0]   o_ptrs;
   logic [NS*CW-1:0]   o_cnt;
   logic [NS-1:0]      o_act;

   l1_ptr_ctrl dut (
      .clk        (clk),
      .reset      (reset),
      .i_req_v    (i_req_v),
      .i_req_r    (i_req_r),
      .i_wr_v     (i_wr_v),
      .i_wr_r     (i_wr_r),
      .i_wr_sid   (i_wr_sid),
      .o_wr_ptr   (o_wr_ptr),
      .i_srst_v   (i_srst_v),
      .i_srst_r   (i_srst_r),
      .i_srst_sid (i_srst_sid),
      .o_ptrs     (o_ptrs),
      .o_cnt      (o_cnt),
      .o_act      (o_act)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic          act;
      logic [CW-1:0] cnt;
      logic [PW-1:0] ptr;
   } exp_t;

   exp_t sb[$];
   exp_t e;
   int   n_vec = 0;
   int   n_err = 0;
   // Reference model of stream 3
   int   m_cnt, m_ptr, m_wr;
   logic m_act;

   function automatic logic [NP*NS-1:0] pmask(input logic [NP-1:0] pm, input int sid);
      logic [NP*NS-1:0] v;
      v = '0;
      for (int p = 0; p < NP; p++) v[p*NS + sid] = pm[p];
      return v;
   endfunction

   function automatic exp_t obs3();
      return {o_act[3], o_cnt[3*CW +: CW], o_ptrs[3*PW +: PW]};
   endfunction

   task automatic push_exp();
      sb.push_back({m_act, CW'(m_cnt), PW'(m_ptr)});
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b0;
      i_req_v = pmask(8'h01, 3); i_wr_v = 1'b1; i_wr_sid = 6'd3;
      i_srst_v = 1'b0; i_srst_sid = '0;
      #12;
      n_vec++; if (o_ptrs !== '0) begin n_err++; $display("FAIL rst_ptrs: got %h want 0", o_ptrs); end
      n_vec++; if (o_cnt !== '0) begin n_err++; $display("FAIL rst_cnt: got %h want 0", o_cnt); end
      n_vec++; if (o_act !== '0) begin n_err++; $display("FAIL rst_act: got %h want 0", o_act); end
      n_vec++; if (i_srst_r !== 1'b0) begin n_err++; $display("FAIL rst_srst_r: got %b want 0", i_srst_r); end
      n_vec++; if ({i_wr_r, |i_req_r} !== 2'b00) begin n_err++; $display("FAIL rst_rdy: got %b want 00", {i_wr_r, |i_req_r}); end
      @(negedge clk); reset = 1'b1;
      tick();
      n_vec++; if (i_srst_r !== 1'b1) begin n_err++; $display("FAIL srst_r_run: got %b want 1", i_srst_r); end
      n_vec++; if ({o_act[3], i_wr_r, |i_req_r} !== 3'b000) begin n_err++; $display("FAIL idle_rdy: got %b want 000", {o_act[3], i_wr_r, |i_req_r}); end
      i_req_v = '0; i_wr_v = 1'b0;
      m_cnt = 0; m_ptr = 0; m_wr = 0; m_act = 1'b0;
   endtask

   task automatic test_srst();
      i_srst_v = 1'b1; i_srst_sid = 6'd3; i_req_v = pmask(8'h01, 3);
      #1;
      n_vec++; if (i_req_r !== '0) begin n_err++; $display("FAIL srst_idle_rd: got %b want 0", |i_req_r); end
      push_exp(); tick(); i_srst_v = 1'b0;
      e = sb.pop_front(); n_vec++;
      if (obs3() !== e) begin n_err++; $display("FAIL srst_flush: got %h want %h", obs3(), e); end
      #1;
      n_vec++; if (i_req_r !== '0) begin n_err++; $display("FAIL flush_rd: got %b want 0", |i_req_r); end
      m_act = 1'b1; push_exp(); tick();
      e = sb.pop_front(); n_vec++;
      if (obs3() !== e) begin n_err++; $display("FAIL srst_active: got %h want %h", obs3(), e); end
      // ACTIVE but empty: still no grant
      n_vec++; if (i_req_r !== '0) begin n_err++; $display("FAIL empty_rd: got %b want 0", |i_req_r); end
      i_req_v = '0;
   endtask

   task automatic test_write_read();
      for (int i = 0; i < 5; i++) begin
         i_wr_v = 1'b1; i_wr_sid = 6'd3;
         #1;
         n_vec++; if ({i_wr_r, o_wr_ptr} !== {1'b1, PW'(m_wr)}) begin n_err++; $display("FAIL wr_ptr_seq: got %b/%0d want 1/%0d", i_wr_r, o_wr_ptr, m_wr); end
         m_wr = (m_wr + 1) % D; m_cnt++;
         push_exp(); tick();
         e = sb.pop_front(); n_vec++;
         if (obs3() !== e) begin n_err++; $display("FAIL wr_cnt: got %h want %h", obs3(), e); end
      end
      i_wr_v = 1'b0;
      i_req_v = pmask(8'b1010_0101, 3);
      #1;
      n_vec++; if (i_req_r !== pmask(8'b1010_0101, 3)) begin n_err++; $display("FAIL rd_all4: got %h want %h", i_req_r[NS*NP-1:0] & pmask(8'hFF, 3), pmask(8'b1010_0101, 3)); end
      m_ptr = (m_ptr + 4) % D; m_cnt -= 4;
      push_exp(); tick();
      e = sb.pop_front(); n_vec++;
      if (obs3() !== e) begin n_err++; $display("FAIL rd_all4_upd: got %h want %h", obs3(), e); end
      i_req_v = '0;
   endtask

   task automatic test_partial_grant();
      i_wr_v = 1'b1; i_wr_sid = 6'd3;
      m_wr = (m_wr + 1) % D; m_cnt++;
      push_exp(); tick();
      e = sb.pop_front(); n_vec++;
      if (obs3() !== e) begin n_err++; $display("FAIL pg_fill: got %h want %h", obs3(), e); end
      i_wr_v = 1'b0;
      i_req_v = pmask(8'b0101_0010, 3);
      #1;
      n_vec++; if (i_req_r !== pmask(8'b0001_0010, 3)) begin n_err++; $display("FAIL pg_rdy: got port6=%b port1=%b port4=%b want 0 1 1", i_req_r[6*NS+3], i_req_r[1*NS+3], i_req_r[4*NS+3]); end
      m_ptr = (m_ptr + 2) % D; m_cnt -= 2;
      push_exp(); tick();
      e = sb.pop_front(); n_vec++;
      if (obs3() !== e) begin n_err++; $display("FAIL pg_upd: got %h want %h", obs3(), e); end
      i_req_v = '0;
   endtask

   task automatic test_wrap_full();
      for (int i = 0; i < 8; i++) begin
         i_wr_v = 1'b1; i_wr_sid = 6'd3; m_wr = (m_wr + 1) % D; m_cnt++;
         push_exp(); tick();
         e = sb.pop_front(); n_vec++;
         if (obs3() !== e) begin n_err++; $display("FAIL wrap_fill8: got %h want %h", obs3(), e); end
      end
      i_wr_v = 1'b0; i_req_v = pmask(8'hFF, 3);
      #1;
      n_vec++; if (i_req_r !== pmask(8'hFF, 3)) begin n_err++; $display("FAIL rd8_rdy: got %b want all", |i_req_r); end
      m_ptr = (m_ptr + 8) % D; m_cnt -= 8;
      push_exp(); tick();
      e = sb.pop_front(); n_vec++;
      if (obs3() !== e) begin n_err++; $display("FAIL rd8_ptr14: got %h want %h", obs3(), e); end
      i_req_v = '0;
      for (int i = 0; i < 4; i++) begin
         i_wr_v = 1'b1; m_wr = (m_wr + 1) % D; m_cnt++;
         push_exp(); tick();
         e = sb.pop_front(); n_vec++;
         if (obs3() !== e) begin n_err++; $display("FAIL wrap_fill4: got %h want %h", obs3(), e); end
      end
      i_wr_v = 1'b0; i_req_v = pmask(8'h0F, 3);
      m_ptr = (m_ptr + 4) % D; m_cnt -= 4;
      push_exp(); tick();
      e = sb.pop_front(); n_vec++;
      if (obs3() !== e) begin n_err++; $display("FAIL ptr_wrap: got %h want %h", obs3(), e); end
      i_req_v = '0;
      for (int i = 0; i < 16; i++) begin
         i_wr_v = 1'b1;
         #1;
         n_vec++; if ({i_wr_r, o_wr_ptr} !== {1'b1, PW'(m_wr)}) begin n_err++; $display("FAIL fill16_wr: got %b/%0d want 1/%0d", i_wr_r, o_wr_ptr, m_wr); end
         m_wr = (m_wr + 1) % D; m_cnt++;
         push_exp(); tick();
         e = sb.pop_front(); n_vec++;
         if (obs3() !== e) begin n_err++; $display("FAIL fill16_cnt: got %h want %h", obs3(), e); end
      end
      #1;
      n_vec++; if (i_wr_r !== 1'b0) begin n_err++; $display("FAIL full_wr_r: got %b want 0", i_wr_r); end
      push_exp(); tick();
      e = sb.pop_front(); n_vec++;
      if (obs3() !== e) begin n_err++; $display("FAIL full_hold: got %h want %h", obs3(), e); end
      i_wr_v = 1'b0;
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 2; i++) begin
         i_req_v = pmask(8'hFF, 3); m_ptr = (m_ptr + 8) % D; m_cnt -= 8;
         push_exp(); tick();
         e = sb.pop_front(); n_vec++;
         if (obs3() !== e) begin n_err++; $display("FAIL drain8: got %h want %h", obs3(), e); end
      end
      i_req_v = '0; i_wr_v = 1'b1; m_wr = (m_wr + 1) % D; m_cnt++;
      push_exp(); tick();
      e = sb.pop_front(); n_vec++;
      if (obs3() !== e) begin n_err++; $display("FAIL one_entry: got %h want %h", obs3(), e); end
      // cnt=1, write + two readers: only port 3 served, fresh entry not bypassed
      i_req_v = pmask(8'b0010_1000, 3);
      #1;
      n_vec++; if ({i_wr_r, i_req_r} !== {1'b1, pmask(8'b0000_1000, 3)}) begin n_err++; $display("FAIL rw_rdy: got wr=%b p3=%b p5=%b want 1 1 0", i_wr_r, i_req_r[3*NS+3], i_req_r[5*NS+3]); end
      m_wr = (m_wr + 1) % D; m_ptr = (m_ptr + 1) % D;
      push_exp(); tick();
      e = sb.pop_front(); n_vec++;
      if (obs3() !== e) begin n_err++; $display("FAIL rw_same: got %h want %h", obs3(), e); end
      i_req_v = '0; i_wr_v = 1'b0;
   endtask

   task automatic test_srst_block();
      i_srst_v = 1'b1; i_srst_sid = 6'd3; i_wr_v = 1'b1; i_wr_sid = 6'd3;
      i_req_v = pmask(8'h01, 3);
      #1;
      n_vec++; if ({i_wr_r, |i_req_r} !== 2'b00) begin n_err++; $display("FAIL srst_blk: got %b want 00", {i_wr_r, |i_req_r}); end
      m_act = 1'b0;
      push_exp(); tick();
      e = sb.pop_front(); n_vec++;
      if (obs3() !== e) begin n_err++; $display("FAIL srst_blk_hold: got %h want %h", obs3(), e); end
      m_cnt = 0; m_ptr = 0; m_wr = 0;
      push_exp(); tick();
      e = sb.pop_front(); n_vec++;
      if (obs3() !== e) begin n_err++; $display("FAIL flush_extend: got %h want %h", obs3(), e); end
      i_srst_v = 1'b0; i_wr_v = 1'b0; i_req_v = '0;
      m_act = 1'b1;
      push_exp(); tick();
      e = sb.pop_front(); n_vec++;
      if (obs3() !== e) begin n_err++; $display("FAIL flush_done: got %h want %h", obs3(), e); end
      n_vec++; if (o_wr_ptr !== PW'(m_wr)) begin n_err++; $display("FAIL flush_wr_ptr: got %0d want %0d", o_wr_ptr, m_wr); end
   endtask

   task automatic test_async_reset();
      for (int i = 0; i < 3; i++) begin
         i_wr_v = 1'b1; m_wr = (m_wr + 1) % D; m_cnt++;
         push_exp(); tick();
         e = sb.pop_front(); n_vec++;
         if (obs3() !== e) begin n_err++; $display("FAIL ar_fill: got %h want %h", obs3(), e); end
      end
      i_req_v = pmask(8'h03, 3);
      @(negedge clk); #1; reset = 1'b0; #1;
      n_vec++; if ({o_ptrs, o_cnt, o_act} !== '0) begin n_err++; $display("FAIL ar_outs: got cnt3=%0d act=%h want 0", o_cnt[3*CW +: CW], o_act); end
      n_vec++; if ({i_srst_r, i_wr_r, |i_req_r} !== 3'b000) begin n_err++; $display("FAIL ar_rdy: got %b want 000", {i_srst_r, i_wr_r, |i_req_r}); end
      @(negedge clk); reset = 1'b1;
      tick();
      n_vec++; if ({o_act[3], i_wr_r, |i_req_r} !== 3'b000) begin n_err++; $display("FAIL ar_idle: got %b want 000", {o_act[3], i_wr_r, |i_req_r}); end
      i_req_v = '0; i_wr_v = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      test_reset();
      test_srst();
      test_write_read();
      test_partial_grant();
      test_wrap_full();
      test_back_to_back();
      test_srst_block();
      test_async_reset();
      n_vec++; if (sb.size() != 0) begin n_err++; $display("FAIL sb_drain: got %0d left want 0", sb.size()); end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/l1_ptr_ctrl.md
Name: l1_ptr_ctrl

Overview:
Per-stream L1 pointer and occupancy controller for the multi-stream buffer. It sits between the l1_rd_port instances and the L1 BRAM refill path. It accepts the per-port, per-stream read requests, grants them against available entries in port-priority order, and advances each stream's read pointer. It also tracks refill writes and per-stream restarts (flush), and publishes the registered pointer array consumed by the read ports.

Parameters:
nstrms, 64, number of streams
sid_width, $clog2(nstrms), stream id width
nports, 8, number of L1 read ports; must satisfy nports <= 2**ptr_width
ptr_width, 4, per-stream L1 entry pointer width; depth D = 2**ptr_width
cnt_width, ptr_width+1, occupancy counter width, range 0..D
gnt_width, $clog2(nports+1), per-stream per-cycle grant count width

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  asynchronous, active-low reset
i_req_v  in  nports*nstrms  read request valids; bit [p*nstrms+s] = port p requests stream s (from each port's o_req_v)
i_req_r  out  nports*nstrms  matching readies, same layout
i_wr_v  in  1  refill write valid (one L1 entry written)
i_wr_r  out  1  refill write ready
i_wr_sid  in  sid_width  stream of refill write
o_wr_ptr  out  ptr_width  write pointer of i_wr_sid (BRAM write address low bits), combinational
i_srst_v  in  1  stream restart/flush request
i_srst_r  out  1  always 1 when out of reset
i_srst_sid  in  sid_width  stream to restart
o_ptrs  out  nstrms*ptr_width  registered read pointer per stream, to l1_rd_port i_ptrs
o_cnt  out  nstrms*cnt_width  registered occupancy per stream
o_act  out  nstrms  stream is ACTIVE

Behaviour:
- Reset (reset=0, async): all streams are IDLE. rd_ptr=0, wr_ptr=0, cnt=0. o_ptrs=0, o_cnt=0, o_act=0. i_srst_r=0 while in reset, otherwise 1.
- Per-stream FSM:
  - IDLE -> FLUSH on accepted srst for that sid.
  - ACTIVE -> FLUSH on accepted srst.
  - FLUSH -> ACTIVE unconditionally after 1 cycle.
  - In FLUSH: rd_ptr, wr_ptr and cnt are loaded to 0.
  - Reads and writes are ready only in ACTIVE.
  - An srst to a stream already in FLUSH keeps it in FLUSH one more cycle.
- Read grant (combinational from i_req_v and registered cnt):
  - For stream s, rank(p) = number of ports q<p with i_req_v[q][s]=1.
  - i_req_r[p][s] = i_req_v[p][s] & ACTIVE(s) & (rank(p) < cnt(s)).
  - Lower port index has priority, so granted reads are always a contiguous prefix and match the rd-port address offsets ptr+rank.
  - Readies for non-requesting bits = 0.
- Grant count g(s) = popcount(i_req_v[*][s] & i_req_r[*][s]), 0..min(nports,cnt).
- Write: i_wr_r = ACTIVE(i_wr_sid) & (cnt(i_wr_sid) < D) & no srst to the same sid this cycle. A write handshake increments wr_ptr (mod D).
- Update at clock edge for ACTIVE stream s:
  - rd_ptr <= rd_ptr + g (mod D, wrap).
  - cnt <= cnt - g + w, where w is the write-accept bit for s.
  - Simultaneous read and write on the same stream is legal.
  - A read may not consume an entry written in the same cycle (no bypass).
- srst precedence: an srst for sid s in the same cycle as reads or writes of s blocks them. i_req_r for s and i_wr_r for s are forced 0 when i_srst_v & i_srst_sid==s.
- Latency: grant in cycle t -> o_ptrs/o_cnt reflect it at t+1. srst accepted at t -> FLUSH at t+1 -> ACTIVE at t+2, ptrs 0.
- Invariants: cnt never exceeds D and never underflows. o_ptrs and o_cnt are outputs of flops only.

Test Plan:
- Reset then srst sid=3 -> o_act[3]=0 at t+1, =1 at t+2; o_ptrs[3]=0, o_cnt[3]=0; reads to sid 3 during IDLE/FLUSH see ready=0.
- sid 3 ACTIVE, 5 writes (one per cycle) -> o_cnt[3]=5, o_wr_ptr sequence 0..4; ports 0,2,5,7 request sid 3 -> all granted, o_ptrs[3]=4, o_cnt[3]=1 next cycle.
- cnt[3]=2, ports 1,4,6 request sid 3 -> ready on ports 1,4 only, port 6 ready=0; o_ptrs advances by 2, o_cnt[3]=0.
- rd_ptr[3]=14 (D=16), 4 granted reads -> o_ptrs[3]=2 (wrap). Write with cnt=16 -> i_wr_r=0.
- Same cycle: write to sid 3, read grant 1 on sid 3, cnt=1 -> cnt stays 1, ptr+1. Same cycle srst sid 3 plus read and write to sid 3 -> both ready=0, then flush to 0.
- Async reset asserted mid-traffic (between clock edges) -> all outputs 0 immediately, readies 0; after release, streams IDLE until srst.
